// File: rtl/fifo_pkg.sv
// Pointer arithmetic shared by the write- and read-side controllers of the dual-clock FIFO.
// Functions work on 32-bit vectors; callers size-cast to their pointer width.
package fifo_pkg;

  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray pointers are one full lap apart when the top two bits differ and the rest match.
  // The read side reuses this with its own pointer pair for the empty/full relation.
  function automatic logic full_cmp(input logic [31:0] gray_w,
                                    input logic [31:0] gray_r,
                                    input int          addr_size);
    logic [31:0] mask;
    mask = 32'd3 << (addr_size - 1);
    return gray_w == (gray_r ^ mask);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for a gray-coded bus crossing into this clock domain.
// Latency STAGES edges; no backpressure, samples every cycle.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer, full/almost-full, fill level and sticky overflow for the dual-clock FIFO.
// Accepted writes show on all outputs one edge later; writes while full are dropped and flagged.
import fifo_pkg::*;

module wr_ptr_ctrl #(
  parameter int ADDR_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   rd_ptr_i,
  input  logic                 inc_i,
  input  logic [ADDR_SIZE:0]   afull_thresh_i,
  input  logic                 ovf_clr_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 full_o,
  output logic                 afull_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o
);

  localparam int PW = ptr_width(ADDR_SIZE);

  logic [PW-1:0] rptr_s;
  logic [PW-1:0] rbin;
  logic [PW-1:0] bin;
  logic [PW-1:0] bin_n;
  logic [PW-1:0] gray_n;
  logic [PW-1:0] level_n;
  logic          accept;
  logic          full_n;
  logic          afull_n;

  sync_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (rd_ptr_i),
    .q   (rptr_s)
  );

  always_comb begin
    accept  = inc_i & ~full_o;
    bin_n   = bin + PW'(accept);
    gray_n  = PW'(bin2gray(32'(bin_n)));
    rbin    = PW'(gray2bin(32'(rptr_s)));
    full_n  = full_cmp(32'(gray_n), 32'(rptr_s), ADDR_SIZE);
    // Synced read pointer only lags, so this difference can only overstate the fill.
    level_n = bin_n - rbin;
    afull_n = (level_n >= afull_thresh_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin        <= '0;
      ptr_o      <= '0;
      full_o     <= 1'b0;
      afull_o    <= 1'b0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      bin     <= bin_n;
      ptr_o   <= gray_n;
      full_o  <= full_n;
      afull_o <= afull_n;
      level_o <= level_n;
      if (inc_i && full_o) begin
        overflow_o <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

  assign addr_o = bin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Directed checks of wr_ptr_ctrl at ADDR_SIZE=3, SYNC_STAGES=2, threshold 6.
module tb_wr_ptr_ctrl;

  localparam int AS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AS:0]   rd_ptr;
  logic          inc;
  logic [AS:0]   afull_thresh;
  logic          ovf_clr;
  logic [AS:0]   ptr;
  logic [AS-1:0] addr;
  logic          full;
  logic          afull;
  logic [AS:0]   level;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wr_ptr_ctrl #(.ADDR_SIZE(AS), .SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rd_ptr_i       (rd_ptr),
    .inc_i          (inc),
    .afull_thresh_i (afull_thresh),
    .ovf_clr_i      (ovf_clr),
    .ptr_o          (ptr),
    .addr_o         (addr),
    .full_o         (full),
    .afull_o        (afull),
    .level_o        (level),
    .overflow_o     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AS:0] prev;
    int          ones;

    rst = 1'b1; rd_ptr = '0; inc = 1'b0; afull_thresh = 4'd6; ovf_clr = 1'b0;
    step(); step();
    chk("rst_ptr", ptr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Fill: eight writes against a reader parked at 0.
    inc = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      step();
      chk("fill_level", level, w);
      chk("fill_afull", afull, (w >= 6) ? 1 : 0);
      chk("fill_full", full, (w == 8) ? 1 : 0);
      if (w == 1) begin
        chk("first_addr", addr, 1);
        chk("first_ptr", ptr, 4'b0001);
      end
    end
    chk("full_addr", addr, 0);
    chk("full_ptr", ptr, 4'b1100);

    step();
    chk("ovf_ptr_held", ptr, 4'b1100);
    chk("ovf_level", level, 8);
    chk("ovf_set", overflow, 1);

    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", overflow, 1);
    inc = 1'b0;
    step();
    chk("ovf_cleared", overflow, 0);
    ovf_clr = 1'b0;

    // Read release: rd_ptr = gray(1), visible after three edges.
    rd_ptr = 4'b0001;
    step(); step();
    chk("rel_still_full", full, 1);
    step();
    chk("rel_full", full, 0);
    chk("rel_level", level, 7);
    inc = 1'b1;
    step();
    chk("refill_full", full, 1);
    chk("refill_ptr", ptr, 4'b1101);
    chk("refill_level", level, 8);

    // Reader catches up with the writer (bin 9), then tracks it through 40 writes.
    inc = 1'b0;
    rd_ptr = 4'b1101;
    step(); step(); step();
    chk("drain_level", level, 0);
    chk("drain_full", full, 0);
    inc = 1'b1;
    for (int w = 0; w < 40; w++) begin
      prev = ptr;
      rd_ptr = ptr;
      step();
      ones = $countones(ptr ^ prev);
      chk("wrap_onebit", ones, 1);
      chk("wrap_nofull", full, 0);
    end
    chk("wrap_addr", addr, 1);
    chk("wrap_ptr", ptr, 4'b0001);
    inc = 1'b0;
    rd_ptr = ptr;
    step(); step(); step(); step();
    chk("wrap_level", level, 0);

    // Five writes against a reader parked at bin 1, then reset mid-stream.
    inc = 1'b1;
    for (int w = 0; w < 5; w++) step();
    chk("mid_level", level, 5);
    chk("mid_addr", addr, 6);
    inc = 1'b0;
    rst = 1'b1;
    rd_ptr = '0;
    step();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ptr", ptr, 0);
    rst = 1'b0;
    inc = 1'b1;
    step();
    chk("post_rst_addr", addr, 1);
    chk("post_rst_level", level, 1);
    inc = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
